// File: rtl/step_ramp_generator_pkg.sv
// step_ramp_generator shared types and timing defaults.
// FSM states, ramp sub-phases, default parameter values.
package step_ramp_generator_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SETUP = 2'd1,
    S_RUN   = 2'd2
  } state_e;

  // PH_DONE is the single-cycle exit out of RUN.
  typedef enum logic [1:0] {
    PH_CRUISE = 2'd0,
    PH_ACCEL  = 2'd1,
    PH_DECEL  = 2'd2,
    PH_DONE   = 2'd3
  } ramp_ph_e;

  localparam int unsigned DEF_POS_W        = 16;
  localparam int unsigned DEF_PERIOD_W     = 16;
  localparam int unsigned DEF_START_PERIOD = 5000;
  localparam int unsigned DEF_MIN_PERIOD   = 500;
  localparam int unsigned DEF_ACCEL_DEC    = 50;
  localparam int unsigned DEF_PULSE_W      = 4;
  localparam int unsigned DEF_DIR_SETUP    = 4;

endpackage

// File: rtl/step_ramp_generator_if.sv
// Command/status bundle of the step ramp generator.
// master: cmd_valid/cmd_target/stop_req out; slave: step/dir/busy/done/cur_pos out.
interface step_ramp_generator_if
  import step_ramp_generator_pkg::*;
#(
  parameter int unsigned POS_W = DEF_POS_W
);

  logic                    cmd_valid;
  logic                    cmd_ready;
  logic signed [POS_W-1:0] cmd_target;
  logic                    stop_req;
  logic                    step;
  logic                    dir;
  logic                    busy;
  logic                    done;
  logic signed [POS_W-1:0] cur_pos;

  modport master (
    output cmd_valid,
    output cmd_target,
    output stop_req,
    input  cmd_ready,
    input  step,
    input  dir,
    input  busy,
    input  done,
    input  cur_pos
  );

  modport slave (
    input  cmd_valid,
    input  cmd_target,
    input  stop_req,
    output cmd_ready,
    output step,
    output dir,
    output busy,
    output done,
    output cur_pos
  );

endinterface

// File: rtl/step_ramp_generator_step_interval_timer.sv
// Step interval timer: counts 0..period-1 per interval, step high for PULSE_W.
// In: start_i, halt_i (stop at interval end), period_i. Out: step_o, first_o, last_o.
module step_interval_timer #(
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned PULSE_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  input  logic                halt_i,
  input  logic [PERIOD_W-1:0] period_i,
  output logic                step_o,
  output logic                first_o,
  output logic                last_o
);

  localparam logic [PERIOD_W-1:0] ONE = PERIOD_W'(1);
  localparam logic [PERIOD_W-1:0] PW  = PERIOD_W'(PULSE_W);

  logic                act_q;
  logic                act_d;
  logic                step_q;
  logic                step_d;
  logic [PERIOD_W-1:0] cnt_q;
  logic [PERIOD_W-1:0] cnt_d;

  assign first_o = act_q && (cnt_q == '0);
  assign last_o  = act_q && (cnt_q == period_i - ONE);
  assign step_o  = step_q;

  // Back-to-back intervals: the counter wraps at last_o unless halted.
  always_comb begin
    act_d = act_q;
    cnt_d = cnt_q;
    if (start_i) begin
      act_d = 1'b1;
      cnt_d = '0;
    end else if (act_q) begin
      if (last_o) begin
        cnt_d = '0;
        if (halt_i) act_d = 1'b0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end
    step_d = act_d && (cnt_d < PW);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_q  <= 1'b0;
      step_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      act_q  <= act_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/step_ramp_generator.sv
// Trapezoidal step/dir pulse generator toward a signed absolute target.
// Ports: clk, rst_n, bus (slave: cmd handshake, stop_req, step/dir/busy/done/cur_pos).
module step_ramp_generator
  import step_ramp_generator_pkg::*;
#(
  parameter int unsigned POS_W        = DEF_POS_W,
  parameter int unsigned PERIOD_W     = DEF_PERIOD_W,
  parameter int unsigned START_PERIOD = DEF_START_PERIOD,
  parameter int unsigned MIN_PERIOD   = DEF_MIN_PERIOD,
  parameter int unsigned ACCEL_DEC    = DEF_ACCEL_DEC,
  parameter int unsigned PULSE_W      = DEF_PULSE_W,
  parameter int unsigned DIR_SETUP    = DEF_DIR_SETUP
) (
  input logic                 clk,
  input logic                 rst_n,
  step_ramp_generator_if.slave bus
);

  localparam int unsigned CW =
    (POS_W > PERIOD_W ? POS_W : PERIOD_W) + 1;
  localparam int unsigned SC_W =
    DIR_SETUP > 1 ? $clog2(DIR_SETUP) : 1;

  localparam logic [PERIOD_W-1:0] P_START = PERIOD_W'(START_PERIOD);
  localparam logic [PERIOD_W-1:0] P_MIN   = PERIOD_W'(MIN_PERIOD);
  localparam logic [PERIOD_W:0]   P_STEP  = (PERIOD_W+1)'(ACCEL_DEC);
  localparam logic [PERIOD_W-1:0] R_ONE   = PERIOD_W'(1);
  localparam logic [SC_W-1:0]     SC_LAST = SC_W'(DIR_SETUP - 1);
  localparam logic [SC_W-1:0]     SC_ONE  = SC_W'(1);
  localparam logic signed [POS_W-1:0] P_ONE = POS_W'(1);

  state_e                  state_q;
  logic [SC_W-1:0]         setup_q;
  logic [PERIOD_W-1:0]     period_q;
  logic [PERIOD_W-1:0]     ramp_q;
  logic signed [POS_W-1:0] pos_q;
  logic signed [POS_W-1:0] tgt_q;
  logic                    dir_q;
  logic                    busy_q;
  logic                    done_q;

  logic signed [POS_W-1:0] pos_d;
  logic signed [POS_W-1:0] tgt_d;
  logic signed [POS_W-1:0] ramp_p;
  logic signed [POS_W-1:0] diff;
  logic [POS_W-1:0]        rem;
  logic [PERIOD_W:0]       per_up;
  logic [PERIOD_W:0]       per_dn;
  logic [PERIOD_W-1:0]     up_clamp;
  logic [PERIOD_W-1:0]     dn_clamp;
  ramp_ph_e                ph_d;

  logic t_step;
  logic t_first;
  logic t_last;
  logic t_start;
  logic t_halt;

  step_interval_timer #(
    .PERIOD_W (PERIOD_W),
    .PULSE_W  (PULSE_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (t_start),
    .halt_i   (t_halt),
    .period_i (period_q),
    .step_o   (t_step),
    .first_o  (t_first),
    .last_o   (t_last)
  );

  // Position after this cycle's step, so a stop landing on the
  // step cycle still counts that step.
  always_comb begin
    pos_d = pos_q;
    if (t_first) pos_d = dir_q ? pos_q + P_ONE : pos_q - P_ONE;
  end

  // A soft stop retargets to exactly the steps the decel ramp needs.
  always_comb begin
    ramp_p = POS_W'(ramp_q);
    tgt_d  = tgt_q;
    if (state_q == S_RUN && bus.stop_req) begin
      tgt_d = dir_q ? pos_d + ramp_p : pos_d - ramp_p;
    end
    diff = tgt_d - pos_d;
    rem  = diff[POS_W-1] ? $unsigned(-diff) : $unsigned(diff);
  end

  // One guard bit so neither direction can wrap before the clamp.
  always_comb begin
    per_up   = {1'b0, period_q} + P_STEP;
    per_dn   = {1'b0, period_q} - P_STEP;
    up_clamp = per_up[PERIOD_W-1:0];
    if (per_up > {1'b0, P_START}) up_clamp = P_START;
    dn_clamp = per_dn[PERIOD_W-1:0];
    if (per_dn[PERIOD_W] || per_dn < {1'b0, P_MIN}) dn_clamp = P_MIN;
  end

  always_comb begin
    if (rem == '0) begin
      ph_d = PH_DONE;
    end else if (CW'(rem) <= CW'(ramp_q)) begin
      ph_d = PH_DECEL;
    end else if (period_q > P_MIN) begin
      ph_d = PH_ACCEL;
    end else begin
      ph_d = PH_CRUISE;
    end
  end

  assign t_halt  = t_last && (ph_d == PH_DONE);
  assign t_start = (state_q == S_SETUP) && (setup_q == SC_LAST)
                   && !bus.stop_req;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      setup_q  <= '0;
      period_q <= P_START;
      ramp_q   <= '0;
      pos_q    <= '0;
      tgt_q    <= '0;
      dir_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            if (bus.cmd_target == pos_q) begin
              done_q <= 1'b1;
            end else begin
              tgt_q   <= bus.cmd_target;
              dir_q   <= $signed(bus.cmd_target) > $signed(pos_q);
              busy_q  <= 1'b1;
              setup_q <= '0;
              state_q <= S_SETUP;
            end
          end
        end
        S_SETUP: begin
          // No step issued yet: a stop here ends the move at once.
          if (bus.stop_req) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end else if (setup_q == SC_LAST) begin
            state_q <= S_RUN;
          end else begin
            setup_q <= setup_q + SC_ONE;
          end
        end
        S_RUN: begin
          pos_q <= pos_d;
          if (bus.stop_req) tgt_q <= tgt_d;
          if (t_last) begin
            unique case (ph_d)
              PH_DONE: begin
                busy_q   <= 1'b0;
                done_q   <= 1'b1;
                period_q <= P_START;
                ramp_q   <= '0;
                state_q  <= S_IDLE;
              end
              PH_DECEL: begin
                period_q <= up_clamp;
                ramp_q   <= ramp_q - R_ONE;
              end
              PH_ACCEL: begin
                period_q <= dn_clamp;
                ramp_q   <= ramp_q + R_ONE;
              end
              default: begin
              end
            endcase
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready = ~busy_q;
  assign bus.step      = t_step;
  assign bus.dir       = dir_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.cur_pos   = pos_q;

endmodule

// File: tb/tb_step_ramp_generator.sv
// Scoreboard bench for step_ramp_generator.
// Reference plans moves step by step; monitor checks step edges and done.
`timescale 1ns/1ps
module tb_step_ramp_generator;

  localparam int POS_W    = 16;
  localparam int PERIOD_W = 16;
  localparam int SP       = 100;
  localparam int MP       = 60;
  localparam int AD       = 20;
  localparam int PW       = 4;
  localparam int DS       = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  step_ramp_generator_if #(.POS_W(POS_W)) bus();

  step_ramp_generator #(
    .POS_W        (POS_W),
    .PERIOD_W     (PERIOD_W),
    .START_PERIOD (SP),
    .MIN_PERIOD   (MP),
    .ACCEL_DEC    (AD),
    .PULSE_W      (PW),
    .DIR_SETUP    (DS)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0;
  int n_pass = 0;
  int done_seen = 0;
  int model_pos = 0;

  longint exp_rise[$];
  bit     exp_dir[$];
  longint exp_done_cyc[$];
  int     exp_done_pos[$];
  int     plan_iv[$];

  bit step_prev = 1'b0;
  int hi_cnt = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)",
                  nm, got, exp, cyc);
  endtask

  // Per-step ramp model: interval of each step from distance rules.
  function automatic void build_plan(input int n, input int stop_k);
    int p;
    int r;
    int tot;
    p = SP;
    r = 0;
    tot = n;
    plan_iv.delete();
    for (int i = 1; i <= tot; i++) begin
      plan_iv.push_back(p);
      if (i == stop_k) tot = i + r;
      if (i == tot) break;
      if (tot - i <= r) begin
        p = (p + AD > SP) ? SP : p + AD;
        r--;
      end else if (p > MP) begin
        p = (p - AD < MP) ? MP : p - AD;
        r++;
      end
    end
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (!rst_n) begin
      step_prev = 1'b0;
      hi_cnt = 0;
    end else begin
      if (bus.step && !step_prev) begin
        if (exp_rise.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_step: rise at cycle %0d, none expected",
                   cyc);
        end else begin
          chk("step_rise_cycle", cyc, exp_rise.pop_front());
          chk("step_dir", longint'(bus.dir), longint'(exp_dir.pop_front()));
        end
        hi_cnt = 1;
      end else if (bus.step) begin
        hi_cnt++;
      end else if (step_prev) begin
        chk("pulse_width", hi_cnt, PW);
      end
      if (bus.done) begin
        if (exp_done_cyc.size() == 0) begin
          n_chk++;
          $display("FAIL unexpected_done: done at cycle %0d, none expected",
                   cyc);
        end else begin
          chk("done_cycle", cyc, exp_done_cyc.pop_front());
          chk("done_pos", longint'($signed(bus.cur_pos)),
              exp_done_pos.pop_front());
          chk("done_busy", longint'(bus.busy), 0);
        end
        done_seen++;
      end
      step_prev = bus.step;
    end
  end

  task automatic move(input int tgt, input int stop_k,
                      input bit poke, input bit wait_done);
    int n;
    bit d;
    longint c0;
    longint t;
    longint stop_cyc;
    longint dl;
    int done0;
    @(negedge clk);
    c0 = cyc;
    d = tgt > model_pos;
    n = d ? tgt - model_pos : model_pos - tgt;
    chk("cmd_ready_idle", longint'(bus.cmd_ready), 1);
    done0 = done_seen;
    stop_cyc = 0;
    if (n == 0) begin
      t = c0 + 1;
      exp_done_cyc.push_back(t);
      exp_done_pos.push_back(model_pos);
    end else begin
      build_plan(n, stop_k);
      t = c0 + 1 + DS;
      for (int i = 0; i < plan_iv.size(); i++) begin
        exp_rise.push_back(t);
        exp_dir.push_back(d);
        if (i + 1 == stop_k) stop_cyc = t + 1;
        t += plan_iv[i];
      end
      model_pos = d ? model_pos + plan_iv.size()
                    : model_pos - plan_iv.size();
      exp_done_cyc.push_back(t);
      exp_done_pos.push_back(model_pos);
    end
    bus.cmd_valid = 1'b1;
    bus.cmd_target = 16'(tgt);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    chk("busy_after_accept", longint'(bus.busy), longint'(n != 0));
    if (n != 0) chk("dir_after_accept", longint'(bus.dir), longint'(d));
    if (poke) begin
      while (cyc < c0 + 20) @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_target = 16'(tgt + 9);
      chk("cmd_ready_busy", longint'(bus.cmd_ready), 0);
      @(negedge clk);
      bus.cmd_valid = 1'b0;
    end
    if (stop_cyc != 0) begin
      while (cyc < stop_cyc) @(negedge clk);
      bus.stop_req = 1'b1;
      @(negedge clk);
      bus.stop_req = 1'b0;
    end
    if (wait_done) begin
      dl = t + 20;
      while (done_seen == done0 && cyc < dl) @(negedge clk);
      if (done_seen == done0) begin
        n_chk++;
        $display("FAIL done_timeout: no done by cycle %0d", dl);
      end
    end
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int tg;
    int nn;
    int sk;
    bus.cmd_valid = 1'b0;
    bus.cmd_target = '0;
    bus.stop_req = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_step", longint'(bus.step), 0);
    chk("rst_dir", longint'(bus.dir), 0);
    chk("rst_busy", longint'(bus.busy), 0);
    chk("rst_done", longint'(bus.done), 0);
    chk("rst_pos", longint'($signed(bus.cur_pos)), 0);
    chk("rst_ready", longint'(bus.cmd_ready), 1);

    move(5, 0, 0, 1);
    move(-3, 0, 1, 1);
    move(0, 0, 0, 1);
    move(20, 0, 0, 1);
    move(0, 0, 0, 1);
    move(20, 4, 0, 1);
    move(6, 0, 0, 1);

    // Asynchronous reset in the middle of a step pulse.
    move(30, 0, 0, 0);
    for (int i = 0; i < 50 && !bus.step; i++) @(negedge clk);
    chk("step_before_reset", longint'(bus.step), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_step", longint'(bus.step), 0);
    chk("async_rst_busy", longint'(bus.busy), 0);
    chk("async_rst_pos", longint'($signed(bus.cur_pos)), 0);
    exp_rise.delete();
    exp_dir.delete();
    exp_done_cyc.delete();
    exp_done_pos.delete();
    model_pos = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    move(7, 0, 0, 1);

    for (int k = 0; k < 8; k++) begin
      tg = model_pos + int'($urandom_range(0, 60)) - 30;
      nn = tg > model_pos ? tg - model_pos : model_pos - tg;
      sk = 0;
      if (nn > 0 && $urandom_range(0, 2) == 0)
        sk = int'($urandom_range(1, nn));
      move(tg, sk, (sk == 0 && nn > 0), 1);
    end

    repeat (5) @(negedge clk);
    chk("leftover_steps", exp_rise.size(), 0);
    chk("leftover_dones", exp_done_cyc.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
